// File: rtl/hit_resolver_pkg.sv
// Shared encodings for the hit resolver: attack FSM animation codes and resolver states.
package hit_resolver_pkg;

   localparam int POS_W    = 10;
   localparam int GEO_W    = 12;
   localparam int HEALTH_W = 8;
   localparam int STUN_W   = 8;
   localparam int COMBO_W  = 4;

   typedef enum logic [3:0] {
      ANIM_IDLE = 4'd0,
      ANIM_ATK1 = 4'd1,
      ANIM_ATK2 = 4'd2
   } anim_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ARMED,
      ST_SPENT,
      ST_KO
   } res_state_e;

   function automatic logic is_attack(input logic [3:0] anim);
      return (anim == ANIM_ATK1) || (anim == ANIM_ATK2);
   endfunction

endpackage

// File: rtl/hit_resolver_if.sv
// Frame-tick inputs from the attack FSM / defender and resolved outputs to HUD and defender logic.
interface hit_resolver_if;
   import hit_resolver_pkg::*;

   logic                SCEN;
   logic                round_reset;
   logic                attack_active;
   logic [3:0]          anim_state;
   logic [POS_W-1:0]    atk_x;
   logic                atk_facing;
   logic [POS_W-1:0]    def_x;
   logic                def_blocking;

   logic                hit_pulse;
   logic                block_pulse;
   logic [HEALTH_W-1:0] def_health;
   logic                def_stunned;
   logic [COMBO_W-1:0]  combo_count;
   logic                ko;

   modport master (
      output SCEN, round_reset, attack_active, anim_state, atk_x, atk_facing, def_x, def_blocking,
      input  hit_pulse, block_pulse, def_health, def_stunned, combo_count, ko
   );

   modport slave (
      input  SCEN, round_reset, attack_active, anim_state, atk_x, atk_facing, def_x, def_blocking,
      output hit_pulse, block_pulse, def_health, def_stunned, combo_count, ko
   );

endinterface

// File: rtl/hit_resolver_hitbox_overlap.sv
// Combinational hitbox/hurtbox test in signed 12-bit space; bounds may go negative unclamped.
module hitbox_overlap
   import hit_resolver_pkg::*;
#(
   parameter int HB_OFFSET = 16,
   parameter int HURT_W    = 32
) (
   input  logic [POS_W-1:0]        atk_x_i,
   input  logic                    atk_facing_i,
   input  logic signed [GEO_W-1:0] reach_i,
   input  logic [POS_W-1:0]        def_x_i,
   output logic                    overlap_o
);

   localparam logic signed [GEO_W-1:0] OFF = GEO_W'(HB_OFFSET);
   localparam logic signed [GEO_W-1:0] HW  = GEO_W'(HURT_W);
   localparam logic signed [GEO_W-1:0] ONE = GEO_W'(1);

   logic signed [GEO_W-1:0] ax, dx, def_hi, lo, hi;

   assign ax     = {{(GEO_W-POS_W){1'b0}}, atk_x_i};
   assign dx     = {{(GEO_W-POS_W){1'b0}}, def_x_i};
   assign def_hi = dx + HW - ONE;

   always_comb begin
      lo = ax + OFF;
      hi = lo + reach_i - ONE;
      if (atk_facing_i) begin
         hi = ax - OFF;
         lo = hi - reach_i + ONE;
      end
   end

   assign overlap_o = (lo <= def_hi) && (dx <= hi);

endmodule

// File: rtl/hit_resolver.sv
// Per-frame hit resolution for one attacker->defender direction: damage, stun, combo, KO.
// Optional COMBO_SCALING_EN halves clean-hit damage once the pre-hit combo is 2 or more.
module hit_resolver
   import hit_resolver_pkg::*;
#(
   parameter int MAX_HEALTH       = 100,
   parameter int ATK1_DMG         = 8,
   parameter int ATK2_DMG         = 15,
   parameter int ATK1_REACH       = 24,
   parameter int ATK2_REACH       = 40,
   parameter int HB_OFFSET        = 16,
   parameter int HURT_W           = 32,
   parameter int HITSTUN_FRAMES   = 12,
   parameter int BLOCKSTUN_FRAMES = 6
) (
   input logic            clk,
   input logic            reset,
   hit_resolver_if.slave  io
);

   localparam logic [COMBO_W-1:0] COMBO_MAX = '1;

   res_state_e           state_q, state_d;
   logic [3:0]           anim_q, anim_d;
   logic [HEALTH_W-1:0]  health_q, health_d;
   logic [STUN_W-1:0]    stun_q, stun_d;
   logic [COMBO_W-1:0]   combo_q, combo_d;
   logic                 ko_q, ko_d;
   logic                 hit_q, hit_d;
   logic                 blk_q, blk_d;

   logic signed [GEO_W-1:0] reach;
   logic                    overlap;
   logic                    hit_det, stunned;
   logic [HEALTH_W-1:0]     base_dmg, dmg, health_hit;

   // Reach and damage follow the latched attack instance, not the live anim_state.
   assign reach = (anim_q == ANIM_ATK2) ? GEO_W'(ATK2_REACH) : GEO_W'(ATK1_REACH);

   hitbox_overlap #(
      .HB_OFFSET (HB_OFFSET),
      .HURT_W    (HURT_W)
   ) u_overlap (
      .atk_x_i      (io.atk_x),
      .atk_facing_i (io.atk_facing),
      .reach_i      (reach),
      .def_x_i      (io.def_x),
      .overlap_o    (overlap)
   );

   assign stunned = (stun_q != '0);
   assign hit_det = (state_q == ST_ARMED) && io.attack_active && overlap;

   always_comb begin
      base_dmg = (anim_q == ANIM_ATK2) ? HEALTH_W'(ATK2_DMG) : HEALTH_W'(ATK1_DMG);
      dmg      = io.def_blocking ? (base_dmg >> 2) : base_dmg;
`ifdef COMBO_SCALING_EN
      if (!io.def_blocking && (combo_q >= COMBO_W'(2)))
         dmg = ((base_dmg >> 1) == '0) ? HEALTH_W'(1) : (base_dmg >> 1);
`endif
   end

   assign health_hit = (dmg >= health_q) ? '0 : health_q - dmg;

   always_comb begin
      state_d  = state_q;
      anim_d   = anim_q;
      health_d = health_q;
      stun_d   = stun_q;
      combo_d  = combo_q;
      ko_d     = ko_q;
      hit_d    = 1'b0;
      blk_d    = 1'b0;

      if (io.round_reset) begin
         state_d  = ST_IDLE;
         anim_d   = ANIM_IDLE;
         health_d = HEALTH_W'(MAX_HEALTH);
         stun_d   = '0;
         combo_d  = '0;
         ko_d     = 1'b0;
      end else if (io.SCEN) begin
         if (hit_det) begin
            health_d = health_hit;
            hit_d    = !io.def_blocking;
            blk_d    = io.def_blocking;
            if (io.def_blocking) begin
               stun_d  = STUN_W'(BLOCKSTUN_FRAMES);
               combo_d = '0;
            end else begin
               stun_d  = STUN_W'(HITSTUN_FRAMES);
               if (!stunned)
                  combo_d = COMBO_W'(1);
               else if (combo_q != COMBO_MAX)
                  combo_d = combo_q + COMBO_W'(1);
            end
            if (health_hit == '0) begin
               ko_d    = 1'b1;
               state_d = ST_KO;
            end else begin
               state_d = ST_SPENT;
            end
         end else begin
            if (stunned) begin
               stun_d = stun_q - STUN_W'(1);
               if (stun_q == STUN_W'(1))
                  combo_d = '0;
            end
            // A changed anim_state ends the instance; a new attack code re-arms on the same tick.
            unique case (state_q)
               ST_IDLE: begin
                  if (is_attack(io.anim_state)) begin
                     state_d = ST_ARMED;
                     anim_d  = io.anim_state;
                  end
               end
               ST_ARMED, ST_SPENT: begin
                  if (io.anim_state != anim_q) begin
                     anim_d  = io.anim_state;
                     state_d = is_attack(io.anim_state) ? ST_ARMED : ST_IDLE;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         anim_q   <= ANIM_IDLE;
         health_q <= HEALTH_W'(MAX_HEALTH);
         stun_q   <= '0;
         combo_q  <= '0;
         ko_q     <= 1'b0;
         hit_q    <= 1'b0;
         blk_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         anim_q   <= anim_d;
         health_q <= health_d;
         stun_q   <= stun_d;
         combo_q  <= combo_d;
         ko_q     <= ko_d;
         hit_q    <= hit_d;
         blk_q    <= blk_d;
      end
   end

   assign io.hit_pulse   = hit_q;
   assign io.block_pulse = blk_q;
   assign io.def_health  = health_q;
   assign io.def_stunned = stunned;
   assign io.combo_count = combo_q;
   assign io.ko          = ko_q;

endmodule

// File: tb/tb_hit_resolver.sv
// Scoreboard bench for hit_resolver: attack-instance reference model, directed plan then random frames.
// Damage expectations follow COMBO_SCALING_EN when the bench is built with that macro.
module tb_hit_resolver;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   hit_resolver_if io();

   hit_resolver dut (
      .clk   (clk),
      .reset (reset),
      .io    (io)
   );

   typedef struct {
      int health;
      bit stunned;
      int combo;
      bit ko;
      bit hitp;
      bit blkp;
   } exp_t;

   exp_t q[$];
   int total = 0;
   int bad   = 0;

   // Model: an attack instance is a run of frames with one attack code; it may land one hit,
   // starting the frame after it was first seen.
   int m_health, m_stun, m_combo, m_inst;
   bit m_ko, m_used;

   int t_ax, t_dx, t_anim;
   bit t_face, t_act, t_blk;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endfunction

   task automatic model_clear();
      m_health = 100; m_stun = 0; m_combo = 0; m_ko = 0; m_inst = 0; m_used = 0;
   endtask

   task automatic model_step(input bit scen, input bit rr, input bit rst);
      exp_t e;
      bit hit, clean;
      int reach, base, dmg, lo, hi;
      hit = 0; clean = 0;
      if (rst || rr) begin
         model_clear();
      end else if (scen) begin
         if (!m_ko && m_inst != 0 && !m_used && t_act) begin
            reach = (m_inst == 2) ? 40 : 24;
            if (!t_face) begin lo = t_ax + 16; hi = lo + reach - 1; end
            else begin hi = t_ax - 16; lo = hi - reach + 1; end
            hit = (lo <= t_dx + 31) && (t_dx <= hi);
         end
         if (hit) begin
            base  = (m_inst == 2) ? 15 : 8;
            clean = !t_blk;
            if (!clean) begin
               dmg = base / 4; m_combo = 0; m_stun = 6;
            end else begin
               dmg = base;
`ifdef COMBO_SCALING_EN
               if (m_combo >= 2) dmg = (base / 2 < 1) ? 1 : base / 2;
`endif
               m_combo = (m_stun > 0) ? ((m_combo < 15) ? m_combo + 1 : 15) : 1;
               m_stun  = 12;
            end
            m_health = (dmg >= m_health) ? 0 : m_health - dmg;
            if (m_health == 0) m_ko = 1;
            m_used = 1;
         end else begin
            if (m_stun > 0) begin
               m_stun--;
               if (m_stun == 0) m_combo = 0;
            end
            if (!m_ko && t_anim != m_inst) begin
               m_inst = (t_anim == 1 || t_anim == 2) ? t_anim : 0;
               m_used = 0;
            end
         end
      end
      e.health = m_health; e.stunned = (m_stun > 0); e.combo = m_combo; e.ko = m_ko;
      e.hitp = hit && clean; e.blkp = hit && !clean;
      q.push_back(e);
   endtask

   task automatic step(input bit scen, input bit rr, input bit rst);
      @(negedge clk);
      io.SCEN = scen; io.round_reset = rr; reset = rst;
      io.attack_active = t_act; io.anim_state = 4'(t_anim);
      io.atk_x = 10'(t_ax); io.atk_facing = t_face; io.def_x = 10'(t_dx); io.def_blocking = t_blk;
      if (scen || rr || rst) model_step(scen, rr, rst);
   endtask

   task automatic scen_n(input int n);
      repeat (n) step(1, 0, 0);
   endtask

   task automatic set_in(input int ax, input bit face, input int anim, input int dx, input bit blk);
      t_ax = ax; t_face = face; t_anim = anim; t_act = 0; t_dx = dx; t_blk = blk;
   endtask

   task automatic one_attack(input int anim);
      t_anim = anim; scen_n(1);
      t_act = 1; scen_n(1);
      t_act = 0; t_anim = 0; scen_n(1);
   endtask

   // Monitor: every clock that consumed SCEN/round_reset/reset presents a scoreboard entry.
   initial begin
      bit ev;
      exp_t e;
      @(negedge clk);
      forever begin
         @(posedge clk);
         ev = reset || io.SCEN || io.round_reset;
         @(negedge clk);
         if (ev) begin
            if (q.size() == 0) begin
               chk("scoreboard_empty", 1, 0);
            end else begin
               e = q.pop_front();
               chk("def_health",  io.def_health,  e.health);
               chk("def_stunned", io.def_stunned, e.stunned);
               chk("combo_count", io.combo_count, e.combo);
               chk("ko",          io.ko,          e.ko);
               chk("hit_pulse",   io.hit_pulse,   e.hitp);
               chk("block_pulse", io.block_pulse, e.blkp);
            end
         end else begin
            chk("hit_pulse_idle",   io.hit_pulse,   0);
            chk("block_pulse_idle", io.block_pulse, 0);
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
      $fatal(1);
   end

   initial begin
      int r;
      reset = 1'b1;
      io.SCEN = 0; io.round_reset = 0; io.attack_active = 0; io.anim_state = 0;
      io.atk_x = 0; io.atk_facing = 0; io.def_x = 0; io.def_blocking = 0;
      set_in(0, 0, 0, 0, 0);
      model_clear();
      step(0, 0, 1); step(0, 0, 1);

      // clean ATK1 right-facing hit, pulse width, 12-frame stun
      set_in(100, 0, 1, 130, 0); scen_n(1);
      t_act = 1; scen_n(1);
      t_act = 0; step(0, 0, 0); step(0, 0, 0);
      scen_n(13); t_anim = 0; scen_n(1);

      // reach boundary: ATK1 misses at def_x=140, ATK2 connects
      set_in(100, 0, 1, 140, 0); scen_n(1);
      t_act = 1; scen_n(2); t_act = 0; t_anim = 0; scen_n(1);
      one_attack(2); scen_n(14);

      // facing left, active held 5 frames -> one hit
      set_in(100, 1, 1, 60, 0); scen_n(1);
      t_act = 1; scen_n(5); t_act = 0; t_anim = 0; scen_n(14);

      // blocked ATK2
      set_in(100, 0, 2, 130, 1); scen_n(1);
      t_act = 1; scen_n(1); t_act = 0; t_anim = 0; scen_n(8);

      // three clean hits chained inside stun
      set_in(100, 0, 0, 130, 0);
      repeat (3) one_attack(1);
      scen_n(14);

      // drive to KO, then further hits ignored
      repeat (10) one_attack(2);
      step(0, 1, 0); step(0, 0, 0);
      one_attack(1);
      step(1, 1, 1); step(0, 0, 0);

      // random frames
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 5) == 0) begin
            r = $urandom_range(0, 9);
            t_anim = (r < 4) ? 0 : (r < 6) ? 1 : (r < 8) ? 2 : $urandom_range(3, 15);
         end
         if ($urandom_range(0, 7) == 0) begin
            if ($urandom_range(0, 9) == 0) begin
               t_ax = $urandom_range(0, 20); t_dx = $urandom_range(0, 30);
            end else begin
               t_ax = $urandom_range(80, 900); t_dx = t_ax + $urandom_range(0, 160) - 80;
            end
            t_face = $urandom_range(0, 1);
         end
         t_act = ($urandom_range(0, 2) != 0);
         t_blk = ($urandom_range(0, 3) == 0);
         step($urandom_range(0, 2) != 0, $urandom_range(0, 59) == 0, $urandom_range(0, 499) == 0);
      end

      step(0, 0, 0); step(0, 0, 0); step(0, 0, 0);
      @(negedge clk);
      chk("scoreboard_drain", q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/hit_resolver.md
Name: hit_resolver

Overview:
- Downstream consumer of the attack FSM outputs (attack_active, anim_state). Once per game frame (SCEN) it tests the attacker hitbox against the defender hurtbox.
- Applies damage, hitstun or blockstun, and KO to the defender.
- Enforces one hit per attack instance.
- One instance is used per attacker→defender direction. Outputs feed the HUD health bar and the defender's movement/animation logic.

Parameters:
- MAX_HEALTH, 100: health after reset/round_reset (8-bit).
- ATK1_DMG, 8: damage for anim_state=1.
- ATK2_DMG, 15: damage for anim_state=2.
- ATK1_REACH, 24: hitbox width in px, ATK1.
- ATK2_REACH, 40: hitbox width in px, ATK2.
- HB_OFFSET, 16: distance from atk_x to the near hitbox edge.
- HURT_W, 32: defender hurtbox width in px.
- HITSTUN_FRAMES, 12: stun frames on a clean hit.
- BLOCKSTUN_FRAMES, 6: stun frames on a blocked hit.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high; clears everything to reset values.
- SCEN  in  1  one-cycle frame-tick enable; all evaluation happens only on SCEN cycles.
- round_reset  in  1  restores health and clears KO and stun; evaluated on any cycle.
- attack_active  in  1  hitbox window from the attack FSM.
- anim_state  in  4  attack FSM state: 0 idle, 1 ATK1, 2 ATK2, others have no hitbox.
- atk_x  in  10  attacker x position in px.
- atk_facing  in  1  0 = facing right, 1 = facing left.
- def_x  in  10  defender hurtbox left edge in px.
- def_blocking  in  1  defender holding block.
- hit_pulse  out  1  one-clk pulse on a clean hit.
- block_pulse  out  1  one-clk pulse on a blocked hit.
- def_health  out  8  defender health.
- def_stunned  out  1  high while the stun counter is nonzero.
- combo_count  out  4  consecutive hits landed while stunned; saturates at 15.
- ko  out  1  latched when health reaches 0.

Behaviour:
- Reset values: def_health=MAX_HEALTH; all other outputs 0; stun counter 0; FSM in IDLE.
- Priority: reset > round_reset > SCEN evaluation.
  - round_reset: health=MAX_HEALTH, ko=0, stun=0, combo_count=0, FSM to IDLE.
- Geometry uses signed 12-bit arithmetic.
  - Facing right: lo = atk_x + HB_OFFSET; hi = lo + reach − 1.
  - Facing left: hi = atk_x − HB_OFFSET; lo = hi − reach + 1.
  - Overlap is true when lo ≤ def_x+HURT_W−1 and def_x ≤ hi.
  - Negative bounds are legal; there is no clamping.
- FSM states, advanced on SCEN only:
  - IDLE: anim_state ∈ {1,2} → ARMED. The instance's anim_state is latched.
  - ARMED: if attack_active && overlap → register a hit, go to SPENT. If anim_state differs from the latched value → IDLE, with the same-cycle re-arm rule below.
  - SPENT: hits are ignored until anim_state differs from the latched value. Then → IDLE, or directly → ARMED if the new anim_state ∈ {1,2}.
  - KO: entered when health reaches 0. Hits are ignored. Only round_reset or reset leaves KO.
- Hit registration happens on the same SCEN edge as detection.
  - Clean hit (def_blocking=0): dmg = ATKn_DMG; stun = HITSTUN_FRAMES; hit_pulse=1.
  - Blocked hit: dmg = ATKn_DMG >> 2; stun = BLOCKSTUN_FRAMES; block_pulse=1.
  - def_health = health − dmg, saturating at 0; ko is set the same edge health becomes 0.
  - Pulses are exactly 1 clk wide and are cleared on the next clk regardless of SCEN.
- Stun counter:
  - Decrements by 1 per SCEN while nonzero; def_stunned = (counter != 0).
  - A new hit reloads the counter; it does not add to it.
- Combo counting:
  - A clean hit landing while def_stunned=1 increments combo_count, saturating at 15.
  - A clean hit landing while not stunned sets combo_count to 1.
  - combo_count clears on the SCEN edge where the counter reaches 0.
  - A blocked hit clears combo_count.
- A hit and a stun expiry on the same edge: the hit wins (reload).

Optional Feature:
- COMBO_SCALING_EN defined: on a clean hit with pre-hit combo_count ≥ 2, dmg = ATKn_DMG >> 1. The minimum damage is 1.
- Undefined: no scaling. combo_count still counts, and all ports are identical in both builds.

Decomposition:
- Shared package: anim_state encodings (IDLE=0, ATK1=1, ATK2=2, matching the attack FSM) and resolver FSM state constants.
- Sub-module hitbox_overlap: purely combinational; computes the signed lo/hi bounds and the overlap flag from atk_x, atk_facing, reach and def_x.

Test Plan:
- atk_x=100, facing right, ATK1, def_x=130, attack_active on one SCEN → hit_pulse 1 clk; health 100→92; def_stunned for 12 SCENs.
- Same setup with def_x=140: ATK1 gives no hit. Rerun with ATK2 → hit; health 100→85.
- Facing left, atk_x=100, def_x=60, ATK1 → overlap (hitbox 61..84); hit. Then attack_active held 5 SCENs → exactly one hit.
- def_blocking=1, ATK2 → block_pulse; health −3; stun 6; combo_count=0.
- Three clean ATK1 hits, each within stun → combo_count=3. Damage 8,8,8 with macro off; 8,8,4 with COMBO_SCALING_EN on.
- Health 5, clean ATK1 → health 0 and ko=1; further hits ignored. round_reset asserted between SCEN pulses → health 100, ko=0 next clk. round_reset with reset both high → reset values.
